// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding memory request, a 2-entry instruction FIFO,
// redirect flush with stale-response dropping, and halt on a termination opcode.
module if_stage #(
  parameter logic [63:0] RESET_PC    = 64'h0000_0000_8000_0000,
  parameter logic [6:0]  TERM_OPCODE = 7'h6b
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [63:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_addr,
  output logic        halted,
  output logic [1:0]  dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // imem_req_valid/addr hold until accepted unless a redirect withdraws them.
  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] req_addr_q, req_addr_d;
  logic        outst_q, outst_d;
  logic        drop_q, drop_d;
  logic        head_q, head_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] data_q [2];
  logic [63:0] addr_q [2];

  logic req_fire, resp_hit, enq, deq, wr_idx, is_term;

  // Credit: nothing outstanding (covers a pending drop) and room left in the FIFO.
  assign imem_req_valid = rst_n && (state_q == S_REQ) && !outst_q &&
                          (count_q != 2'd2) && !redirect_valid;
  assign imem_req_addr  = pc_q;

  assign inst_valid  = (count_q != 2'd0);
  assign inst        = data_q[head_q];
  assign inst_addr   = addr_q[head_q];
  assign halted      = (state_q == S_HALT);
  assign dbg_state_o = state_q;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign resp_hit = imem_resp_valid && outst_q;
  assign enq      = resp_hit && !drop_q && !redirect_valid;
  assign deq      = inst_valid && inst_ready;
  assign wr_idx   = head_q ^ count_q[0];
  assign is_term  = (imem_resp_data[6:0] == TERM_OPCODE);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    head_d     = head_q;
    count_d    = count_q;
    if (redirect_valid) begin
      // A response landing with the redirect is simply discarded; otherwise remember to drop it.
      state_d = S_REQ;
      pc_d    = {redirect_pc[63:2], 2'b00};
      head_d  = 1'b0;
      count_d = 2'd0;
      outst_d = outst_q && !imem_resp_valid;
      drop_d  = outst_q && !imem_resp_valid;
    end else begin
      if (req_fire) begin
        state_d    = S_WAIT;
        pc_d       = pc_q + 64'd4;
        req_addr_d = pc_q;
        outst_d    = 1'b1;
      end
      if (resp_hit) begin
        outst_d = 1'b0;
        drop_d  = 1'b0;
        if (!drop_q) state_d = is_term ? S_HALT : S_REQ;
      end
      if (deq) head_d = ~head_q;
      count_d = count_q + {1'b0, enq} - {1'b0, deq};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      req_addr_q <= 64'd0;
      outst_q    <= 1'b0;
      drop_q     <= 1'b0;
      head_q     <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q[0] <= 32'd0;
      data_q[1] <= 32'd0;
      addr_q[0] <= 64'd0;
      addr_q[1] <= 64'd0;
    end else if (enq) begin
      data_q[wr_idx] <= imem_resp_data;
      addr_q[wr_idx] <= req_addr_q;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: request-address and instruction scoreboards fed by
// the directed steps, popped when the DUT issues a request or hands an instruction to decode.
module tb_if_stage;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_addr;
  logic        halted;
  logic [1:0]  dbg_state;

  if_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_addr      (inst_addr),
    .halted         (halted),
    .dbg_state_o    (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Scoreboards
  logic [63:0] exp_req_q[$];
  logic [95:0] exp_inst_q[$];
  int          n_checks = 0;
  int          n_err    = 0;

  logic        mem_auto   = 1'b0;
  logic        force_resp = 1'b0;
  logic [31:0] force_data = 32'd0;
  logic [63:0] term_addr  = 64'd0;

  function automatic logic [31:0] mem_data(input logic [63:0] a);
    if (a == term_addr) return 32'h0000_006b;
    return {a[24:0], 7'h13};
  endfunction

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock: sample at negedge, then drive memory response just after the rising edge.
  task automatic cycle();
    logic        acc;
    logic [63:0] a;
    logic [63:0] er;
    logic [95:0] ei;
    @(negedge clk);
    acc = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    if (acc) begin
      if (exp_req_q.size() == 0) chk("req_unexpected", 96'(a), 96'(0));
      else begin
        er = exp_req_q.pop_front();
        chk("req_addr", 96'(a), 96'(er));
      end
    end
    if (inst_valid && inst_ready) begin
      if (exp_inst_q.size() == 0) chk("inst_unexpected", {inst_addr, inst}, 96'(0));
      else begin
        ei = exp_inst_q.pop_front();
        chk("inst_entry", {inst_addr, inst}, ei);
      end
    end
    @(posedge clk);
    #1;
    if (force_resp) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = force_data;
    end else if (acc && mem_auto) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_data(a);
    end else begin
      imem_resp_valid = 1'b0;
    end
  endtask

  task automatic run_reqs(input int max);
    int n = 0;
    while (exp_req_q.size() != 0 && n < max) begin
      cycle();
      n++;
    end
    chk("req_done", 96'(exp_req_q.size()), 96'(0));
  endtask

  task automatic drain(input int n);
    repeat (n) cycle();
  endtask

  task automatic push_inst(input logic [63:0] a, input logic [31:0] d);
    exp_inst_q.push_back({a, d});
  endtask

  initial begin
    rst_n           = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'd0;
    redirect_valid  = 1'b0;
    redirect_pc     = 64'd0;
    inst_ready      = 1'b1;

    // Reset values
    #12;
    chk("rst_req_valid", 96'(imem_req_valid), 96'(0));
    chk("rst_inst_valid", 96'(inst_valid), 96'(0));
    chk("rst_halted", 96'(halted), 96'(0));
    chk("rst_state", 96'(dbg_state), 96'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic streaming fetch
    exp_req_q.push_back(RST_PC);
    exp_req_q.push_back(RST_PC + 64'd4);
    exp_req_q.push_back(RST_PC + 64'd8);
    push_inst(RST_PC, mem_data(RST_PC));
    push_inst(RST_PC + 64'd4, mem_data(RST_PC + 64'd4));
    push_inst(RST_PC + 64'd8, mem_data(RST_PC + 64'd8));
    imem_req_ready = 1'b1;
    mem_auto       = 1'b1;
    #1;
    chk("first_req_valid", 96'(imem_req_valid), 96'(1));
    chk("first_req_addr", 96'(imem_req_addr), 96'(RST_PC));
    cycle();
    #1;
    chk("no_bypass", 96'(inst_valid), 96'(0));
    cycle();
    #1;
    chk("inst_next_cycle", 96'(inst_valid), 96'(1));
    chk("inst_next_addr", 96'(inst_addr), 96'(RST_PC));
    run_reqs(20);
    imem_req_ready = 1'b0;
    drain(4);
    chk("s1_inst_empty", 96'(exp_inst_q.size()), 96'(0));

    // Stalled request held stable, withdrawn by redirect in the third cycle
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_8000_0200;
      end
      #1;
      if (i < 2) begin
        chk("stall_valid", 96'(imem_req_valid), 96'(1));
        chk("stall_addr", 96'(imem_req_addr), 96'(RST_PC + 64'hC));
      end else if (i == 2) begin
        chk("stall_withdrawn", 96'(imem_req_valid), 96'(0));
      end else begin
        chk("stall_redir_valid", 96'(imem_req_valid), 96'(1));
        chk("stall_redir_addr", 96'(imem_req_addr), 96'(64'h8000_0200));
      end
      cycle();
      redirect_valid = 1'b0;
    end

    // Decode back-pressure fills the FIFO, then drains in order
    inst_ready = 1'b0;
    imem_req_ready = 1'b1;
    exp_req_q.push_back(64'h8000_0200);
    exp_req_q.push_back(64'h8000_0204);
    drain(4);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("full_req_valid", 96'(imem_req_valid), 96'(0));
      chk("full_inst_valid", 96'(inst_valid), 96'(1));
      chk("full_head", {inst_addr, inst}, {64'h8000_0200, mem_data(64'h8000_0200)});
      cycle();
    end
    push_inst(64'h8000_0200, mem_data(64'h8000_0200));
    push_inst(64'h8000_0204, mem_data(64'h8000_0204));
    push_inst(64'h8000_0208, mem_data(64'h8000_0208));
    exp_req_q.push_back(64'h8000_0208);
    inst_ready = 1'b1;
    run_reqs(20);
    imem_req_ready = 1'b0;
    drain(4);
    chk("s3_inst_empty", 96'(exp_inst_q.size()), 96'(0));

    // Redirect with one entry buffered and a request outstanding
    inst_ready = 1'b0;
    imem_req_ready = 1'b1;
    exp_req_q.push_back(64'h8000_020C);
    exp_req_q.push_back(64'h8000_0210);
    begin
      int n = 0;
      while (exp_req_q.size() > 1 && n < 20) begin
        cycle();
        n++;
      end
    end
    mem_auto = 1'b0;
    cycle();
    cycle();
    #1;
    chk("pre_redir_reqs", 96'(exp_req_q.size()), 96'(0));
    chk("pre_redir_buffered", 96'(inst_valid), 96'(1));
    chk("pre_redir_wait", 96'(dbg_state), 96'(1));
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0000_0000_8000_1002;
    cycle();
    redirect_valid = 1'b0;
    #1;
    chk("flush_inst_valid", 96'(inst_valid), 96'(0));
    inst_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("drop_blocks_req", 96'(imem_req_valid), 96'(0));
      cycle();
    end
    force_resp = 1'b1;
    force_data = 32'h0000_006b;
    cycle();
    force_resp = 1'b0;
    #1;
    chk("stale_resp_cycle_req", 96'(imem_req_valid), 96'(0));
    exp_req_q.push_back(64'h8000_1000);
    push_inst(64'h8000_1000, mem_data(64'h8000_1000));
    mem_auto = 1'b1;
    run_reqs(20);
    imem_req_ready = 1'b0;
    drain(4);
    chk("stale_no_halt", 96'(halted), 96'(0));
    chk("s4_inst_empty", 96'(exp_inst_q.size()), 96'(0));

    // Termination opcode halts fetch; redirect resumes
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0000_0000_8000_0010;
    cycle();
    redirect_valid = 1'b0;
    term_addr = 64'h8000_0010;
    exp_req_q.push_back(64'h8000_0010);
    push_inst(64'h8000_0010, 32'h0000_006b);
    imem_req_ready = 1'b1;
    run_reqs(20);
    cycle();
    #1;
    chk("halt_flag", 96'(halted), 96'(1));
    chk("halt_state", 96'(dbg_state), 96'(2));
    chk("halt_req_valid", 96'(imem_req_valid), 96'(0));
    drain(4);
    #1;
    chk("halt_held", 96'(halted), 96'(1));
    chk("halt_no_req", 96'(imem_req_valid), 96'(0));
    chk("halt_inst_delivered", 96'(exp_inst_q.size()), 96'(0));
    term_addr = 64'd0;
    exp_req_q.push_back(64'h8000_0100);
    push_inst(64'h8000_0100, mem_data(64'h8000_0100));
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0000_0000_8000_0100;
    cycle();
    redirect_valid = 1'b0;
    #1;
    chk("unhalt_flag", 96'(halted), 96'(0));
    chk("unhalt_req_valid", 96'(imem_req_valid), 96'(1));
    chk("unhalt_req_addr", 96'(imem_req_addr), 96'(64'h8000_0100));
    run_reqs(20);
    imem_req_ready = 1'b0;
    drain(4);
    chk("s5_inst_empty", 96'(exp_inst_q.size()), 96'(0));

    // Reset during WAIT, late response ignored
    exp_req_q.push_back(64'h8000_0104);
    imem_req_ready = 1'b1;
    mem_auto = 1'b0;
    cycle();
    chk("midrst_wait", 96'(dbg_state), 96'(1));
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    #1;
    chk("midrst_req_valid", 96'(imem_req_valid), 96'(0));
    chk("midrst_inst_valid", 96'(inst_valid), 96'(0));
    chk("midrst_halted", 96'(halted), 96'(0));
    chk("midrst_state", 96'(dbg_state), 96'(0));
    cycle();
    rst_n = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data  = mem_data(64'h8000_0104);
    #1;
    chk("rerst_req_valid", 96'(imem_req_valid), 96'(1));
    chk("rerst_req_addr", 96'(imem_req_addr), 96'(RST_PC));
    cycle();
    #1;
    chk("late_resp_ignored", 96'(inst_valid), 96'(0));
    chk("late_resp_state", 96'(dbg_state), 96'(0));

    // Simultaneous enqueue and dequeue keep order
    inst_ready = 1'b0;
    exp_req_q.push_back(RST_PC);
    exp_req_q.push_back(RST_PC + 64'd4);
    push_inst(RST_PC, mem_data(RST_PC));
    push_inst(RST_PC + 64'd4, mem_data(RST_PC + 64'd4));
    imem_req_ready = 1'b1;
    mem_auto = 1'b1;
    run_reqs(20);
    inst_ready = 1'b1;
    imem_req_ready = 1'b0;
    #1;
    chk("enqdeq_head_before", 96'(inst_addr), 96'(RST_PC));
    cycle();
    #1;
    chk("enqdeq_valid_after", 96'(inst_valid), 96'(1));
    chk("enqdeq_head_after", 96'(inst_addr), 96'(RST_PC + 64'd4));
    drain(4);
    chk("final_inst_empty", 96'(exp_inst_q.size()), 96'(0));
    chk("final_req_empty", 96'(exp_req_q.size()), 96'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
